// File: rtl/i2c_seq_pkg.sv
// Shared types and widths for the I2C register-access sequencer.
package i2c_seq_pkg;

   localparam int unsigned DEV_ADDR_W = 7;
   localparam int unsigned BYTE_W     = 8;
   localparam int unsigned WDOG_W     = 24;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD1,
      ST_DATA1,
      ST_CMD2,
      ST_DATA2,
      ST_RDATA,
      ST_WAIT_IDLE,
      ST_RESP
   } seq_state_t;

   typedef enum logic [1:0] {
      ERR_OK      = 2'b00,
      ERR_NACK    = 2'b01,
      ERR_TIMEOUT = 2'b10
   } seq_err_t;

endpackage

// File: rtl/i2c_seq_watchdog.sv
// Progress watchdog: counts cycles since the last clear while enabled and
// flags expiry once TIMEOUT_CYCLES cycles have elapsed without a clear.
module i2c_seq_watchdog
   import i2c_seq_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 100000
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   logic [WDOG_W-1:0] count;

   // Expiry is seen in the TIMEOUT_CYCLES-th cycle after a clear, so the
   // owner can abort on that edge.
   assign expired = (count == WDOG_W'(TIMEOUT_CYCLES - 1));

   // Cycle counter; saturates at the expiry value until cleared.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && !expired) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/i2c_reg_sequencer.sv
// Turns single-register read/write requests into the i2c_master command and
// data stream sequence, with sticky NACK collection and a progress watchdog.
module i2c_reg_sequencer
   import i2c_seq_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 100000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_read,
   input  logic [DEV_ADDR_W-1:0] req_dev_addr,
   input  logic [BYTE_W-1:0]     req_reg_addr,
   input  logic [BYTE_W-1:0]     req_wdata,
   output logic                  rsp_valid,
   output logic [BYTE_W-1:0]     rsp_rdata,
   output logic [1:0]            rsp_err,
   output logic [DEV_ADDR_W-1:0] m_cmd_address,
   output logic                  m_cmd_start,
   output logic                  m_cmd_read,
   output logic                  m_cmd_write,
   output logic                  m_cmd_write_multiple,
   output logic                  m_cmd_stop,
   output logic                  m_cmd_valid,
   input  logic                  m_cmd_ready,
   output logic [BYTE_W-1:0]     m_data_tdata,
   output logic                  m_data_tvalid,
   output logic                  m_data_tlast,
   input  logic                  m_data_tready,
   input  logic [BYTE_W-1:0]     s_data_tdata,
   input  logic                  s_data_tvalid,
   input  logic                  s_data_tlast,
   output logic                  s_data_tready,
   input  logic                  busy,
   input  logic                  missed_ack
);

   seq_state_t        state;
   logic              rd_q;
   logic [BYTE_W-1:0] reg_q;
   logic [BYTE_W-1:0] wdata_q;
   logic [BYTE_W-1:0] rdata_q;
   logic              nack_q;
   logic              nack_now;
   logic              wd_clear;
   logic              wd_expired;
   logic              unused_tlast;

   assign req_ready            = (state == ST_IDLE) && !busy;
   assign m_cmd_write_multiple = 1'b0;
   assign nack_now             = nack_q || missed_ack;
   // Single-byte reads: the last flag from the master carries no information.
   assign unused_tlast         = s_data_tlast;

   // Watchdog restart on every handshake, state change or abort.
   always_comb begin
      wd_clear = 1'b0;
      case (state)
         ST_IDLE:           wd_clear = req_valid && req_ready;
         ST_CMD1, ST_CMD2:  wd_clear = m_cmd_valid && m_cmd_ready;
         ST_DATA1, ST_DATA2: wd_clear = m_data_tvalid && m_data_tready;
         ST_RDATA:          wd_clear = s_data_tready && s_data_tvalid;
         ST_WAIT_IDLE:      wd_clear = !busy;
         default:           wd_clear = 1'b1;
      endcase
      if (wd_expired) begin
         wd_clear = 1'b1;
      end
   end

   i2c_seq_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk     (clk),
      .rst     (rst),
      .clear   (wd_clear),
      .enable  (state != ST_IDLE),
      .expired (wd_expired)
   );

   // Sequencer FSM with registered stream outputs and response.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= ST_IDLE;
         rd_q          <= 1'b0;
         reg_q         <= '0;
         wdata_q       <= '0;
         rdata_q       <= '0;
         nack_q        <= 1'b0;
         m_cmd_address <= '0;
         m_cmd_start   <= 1'b0;
         m_cmd_read    <= 1'b0;
         m_cmd_write   <= 1'b0;
         m_cmd_stop    <= 1'b0;
         m_cmd_valid   <= 1'b0;
         m_data_tdata  <= '0;
         m_data_tvalid <= 1'b0;
         m_data_tlast  <= 1'b0;
         s_data_tready <= 1'b0;
         rsp_valid     <= 1'b0;
         rsp_rdata     <= '0;
         rsp_err       <= ERR_OK;
      end else begin
         rsp_valid <= 1'b0;
         if (state != ST_IDLE && missed_ack) begin
            nack_q <= 1'b1;
         end
         if (wd_expired && state != ST_IDLE && state != ST_RESP) begin
            m_cmd_valid   <= 1'b0;
            m_data_tvalid <= 1'b0;
            s_data_tready <= 1'b0;
            rsp_valid     <= 1'b1;
            rsp_rdata     <= '0;
            rsp_err       <= ERR_TIMEOUT;
            state         <= ST_RESP;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (req_valid && req_ready) begin
                     rd_q          <= req_read;
                     reg_q         <= req_reg_addr;
                     wdata_q       <= req_wdata;
                     rdata_q       <= '0;
                     nack_q        <= 1'b0;
                     m_cmd_address <= req_dev_addr;
                     m_cmd_start   <= 1'b1;
                     m_cmd_read    <= 1'b0;
                     m_cmd_write   <= 1'b1;
                     m_cmd_stop    <= 1'b0;
                     m_cmd_valid   <= 1'b1;
                     state         <= ST_CMD1;
                  end
               end
               ST_CMD1: begin
                  if (m_cmd_ready) begin
                     m_cmd_valid   <= 1'b0;
                     m_data_tdata  <= reg_q;
                     m_data_tlast  <= 1'b1;
                     m_data_tvalid <= 1'b1;
                     state         <= ST_DATA1;
                  end
               end
               ST_DATA1: begin
                  if (m_data_tready) begin
                     m_data_tvalid <= 1'b0;
                     m_cmd_start   <= rd_q;
                     m_cmd_read    <= rd_q;
                     m_cmd_write   <= !rd_q;
                     m_cmd_stop    <= 1'b1;
                     m_cmd_valid   <= 1'b1;
                     state         <= ST_CMD2;
                  end
               end
               ST_CMD2: begin
                  if (m_cmd_ready) begin
                     m_cmd_valid <= 1'b0;
                     if (rd_q) begin
                        s_data_tready <= 1'b1;
                        state         <= ST_RDATA;
                     end else begin
                        m_data_tdata  <= wdata_q;
                        m_data_tlast  <= 1'b1;
                        m_data_tvalid <= 1'b1;
                        state         <= ST_DATA2;
                     end
                  end
               end
               ST_DATA2: begin
                  if (m_data_tready) begin
                     m_data_tvalid <= 1'b0;
                     state         <= ST_WAIT_IDLE;
                  end
               end
               ST_RDATA: begin
                  if (s_data_tvalid) begin
                     s_data_tready <= 1'b0;
                     rdata_q       <= s_data_tdata;
                     state         <= ST_WAIT_IDLE;
                  end
               end
               ST_WAIT_IDLE: begin
                  if (!busy) begin
                     rsp_valid <= 1'b1;
                     rsp_err   <= nack_now ? ERR_NACK : ERR_OK;
                     rsp_rdata <= (rd_q && !nack_now) ? rdata_q : '0;
                     state     <= ST_RESP;
                  end
               end
               ST_RESP: state <= ST_IDLE;
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// Scoreboard bench for i2c_reg_sequencer: a behavioural master model drives
// the stream handshakes and checks the command/data stream; a separate
// monitor checks every response against the expected-response queue.
module tb_i2c_reg_sequencer;

   localparam int unsigned TO = 50;

   typedef struct packed {
      logic [6:0] addr;
      logic       start;
      logic       read;
      logic       write;
      logic       stop;
   } cmd_t;

   typedef struct packed {
      logic       rd;
      logic       nack;
      logic [7:0] rbyte;
   } txn_t;

   typedef struct packed {
      logic [7:0] rdata;
      logic [1:0] err;
   } rsp_t;

   logic       clk;
   logic       rst;
   logic       req_valid, req_ready, req_read;
   logic [6:0] req_dev_addr;
   logic [7:0] req_reg_addr, req_wdata;
   logic       rsp_valid;
   logic [7:0] rsp_rdata;
   logic [1:0] rsp_err;
   logic [6:0] m_cmd_address;
   logic       m_cmd_start, m_cmd_read, m_cmd_write, m_cmd_write_multiple, m_cmd_stop;
   logic       m_cmd_valid, m_cmd_ready;
   logic [7:0] m_data_tdata;
   logic       m_data_tvalid, m_data_tlast, m_data_tready;
   logic [7:0] s_data_tdata;
   logic       s_data_tvalid, s_data_tlast, s_data_tready;
   logic       busy, missed_ack;

   logic       busy_m, force_busy, hold_cmd, hold_sdata, abort_ok;
   int unsigned stall_pct;
   int unsigned cyc;
   int unsigned bfall_cyc;
   int         tests, fails;

   cmd_t       cmd_q[$];
   logic [8:0] data_q[$];
   txn_t       txn_q[$];
   rsp_t       rsp_q[$];

   assign busy = busy_m | force_busy;

   i2c_reg_sequencer #(
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk                  (clk),
      .rst                  (rst),
      .req_valid            (req_valid),
      .req_ready            (req_ready),
      .req_read             (req_read),
      .req_dev_addr         (req_dev_addr),
      .req_reg_addr         (req_reg_addr),
      .req_wdata            (req_wdata),
      .rsp_valid            (rsp_valid),
      .rsp_rdata            (rsp_rdata),
      .rsp_err              (rsp_err),
      .m_cmd_address        (m_cmd_address),
      .m_cmd_start          (m_cmd_start),
      .m_cmd_read           (m_cmd_read),
      .m_cmd_write          (m_cmd_write),
      .m_cmd_write_multiple (m_cmd_write_multiple),
      .m_cmd_stop           (m_cmd_stop),
      .m_cmd_valid          (m_cmd_valid),
      .m_cmd_ready          (m_cmd_ready),
      .m_data_tdata         (m_data_tdata),
      .m_data_tvalid        (m_data_tvalid),
      .m_data_tlast         (m_data_tlast),
      .m_data_tready        (m_data_tready),
      .s_data_tdata         (s_data_tdata),
      .s_data_tvalid        (s_data_tvalid),
      .s_data_tlast         (s_data_tlast),
      .s_data_tready        (s_data_tready),
      .busy                 (busy),
      .missed_ack           (missed_ack)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: the transaction expressed as the stream it must produce.
   task automatic model_push(input bit rd, input logic [6:0] dev, input logic [7:0] ra,
                             input logic [7:0] wd, input logic [7:0] rb, input bit nack,
                             input bit timeout);
      rsp_t r;
      txn_t t;
      if (timeout) begin
         r.rdata = 8'h00;
         r.err   = 2'b10;
         rsp_q.push_back(r);
         return;
      end
      cmd_q.push_back('{addr: dev, start: 1'b1, read: 1'b0, write: 1'b1, stop: 1'b0});
      data_q.push_back({1'b1, ra});
      if (rd) begin
         cmd_q.push_back('{addr: dev, start: 1'b1, read: 1'b1, write: 1'b0, stop: 1'b1});
      end else begin
         cmd_q.push_back('{addr: dev, start: 1'b0, read: 1'b0, write: 1'b1, stop: 1'b1});
         data_q.push_back({1'b1, wd});
      end
      t.rd    = rd;
      t.nack  = nack;
      t.rbyte = rb;
      txn_q.push_back(t);
      r.err   = nack ? 2'b01 : 2'b00;
      r.rdata = (rd && !nack) ? rb : 8'h00;
      rsp_q.push_back(r);
   endtask

   task automatic drive_req(input bit rd, input logic [6:0] dev, input logic [7:0] ra,
                            input logic [7:0] wd);
      int n;
      req_read     = rd;
      req_dev_addr = dev;
      req_reg_addr = ra;
      req_wdata    = wd;
      req_valid    = 1'b1;
      n = 0;
      #1;
      while (!req_ready && n < 2000) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk("req_accept", req_ready, 1'b1);
      @(negedge clk);
      req_valid    = 1'b0;
      req_read     = 1'($urandom);
      req_dev_addr = 7'($urandom);
      req_reg_addr = 8'($urandom);
      req_wdata    = 8'($urandom);
   endtask

   task automatic issue(input bit rd, input logic [6:0] dev, input logic [7:0] ra,
                        input logic [7:0] wd, input logic [7:0] rb, input bit nack,
                        input bit timeout);
      model_push(rd, dev, ra, wd, rb, nack, timeout);
      drive_req(rd, dev, ra, wd);
   endtask

   task automatic wait_drain(input string name);
      int n;
      n = 0;
      while (rsp_q.size() != 0 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk(name, rsp_q.size(), 0);
   endtask

   // Master model and command/data stream monitor.
   initial begin : master
      int   phase;      // 0 none, 1 reg byte, 2 second cmd, 3 read byte, 4 write byte
      int   drop_cnt;
      bit   nack_done, s_drop, cmd_hs, data_hs, s_hs;
      bit   pc_valid, pc_hs, pd_valid, pd_hs;
      cmd_t pc_pay, e, cur_cmd;
      logic [8:0] pd_pay, ed;
      txn_t cur;
      m_cmd_ready   = 1'b0;
      m_data_tready = 1'b0;
      s_data_tvalid = 1'b0;
      s_data_tdata  = 8'h00;
      s_data_tlast  = 1'b0;
      missed_ack    = 1'b0;
      busy_m        = 1'b0;
      bfall_cyc     = 0;
      phase = 0; drop_cnt = 0; nack_done = 0; s_drop = 0;
      pc_valid = 0; pc_hs = 0; pd_valid = 0; pd_hs = 0;
      pc_pay = '0; pd_pay = '0; cur = '0;
      forever begin
         @(negedge clk);
         missed_ack = 1'b0;
         if (rst) begin
            busy_m = 1'b0; phase = 0; drop_cnt = 0; s_drop = 0;
            s_data_tvalid = 1'b0; m_cmd_ready = 1'b0; m_data_tready = 1'b0;
            pc_valid = 0; pd_valid = 0;
            continue;
         end
         if (s_drop) begin
            s_data_tvalid = 1'b0;
            s_drop = 0;
         end
         cur_cmd = '{addr: m_cmd_address, start: m_cmd_start, read: m_cmd_read,
                     write: m_cmd_write, stop: m_cmd_stop};
         if (pc_valid && !pc_hs) begin
            if (!m_cmd_valid) begin
               if (!abort_ok) chk("cmd_valid_withdrawn", m_cmd_valid, 1'b1);
            end else begin
               chk("cmd_payload_stable", cur_cmd, pc_pay);
            end
         end
         if (pd_valid && !pd_hs) begin
            if (!m_data_tvalid) begin
               if (!abort_ok) chk("data_valid_withdrawn", m_data_tvalid, 1'b1);
            end else begin
               chk("data_payload_stable", {m_data_tlast, m_data_tdata}, pd_pay);
            end
         end
         if (drop_cnt > 0) begin
            drop_cnt--;
            if (drop_cnt == 0) begin
               busy_m    = 1'b0;
               bfall_cyc = cyc;
            end
         end
         m_cmd_ready   = !hold_cmd && ($urandom_range(99) >= stall_pct);
         m_data_tready = ($urandom_range(99) >= stall_pct);
         if (phase == 3 && !s_data_tvalid && !hold_sdata && $urandom_range(99) >= stall_pct) begin
            s_data_tvalid = 1'b1;
            s_data_tdata  = cur.rbyte;
         end
         if (phase == 1 && m_data_tvalid && cur.nack && !nack_done) begin
            missed_ack = 1'b1;
            nack_done  = 1;
         end
         cmd_hs  = m_cmd_valid && m_cmd_ready;
         data_hs = m_data_tvalid && m_data_tready;
         s_hs    = s_data_tvalid && s_data_tready;
         if (cmd_hs) begin
            if (cmd_q.size() == 0) begin
               chk("cmd_unexpected", cur_cmd, '0);
            end else begin
               e = cmd_q.pop_front();
               chk("cmd_fields", cur_cmd, e);
               chk("cmd_write_multiple", m_cmd_write_multiple, 1'b0);
               if (e.start && !e.read && !e.stop) begin
                  if (txn_q.size() != 0) cur = txn_q.pop_front();
                  nack_done = 0;
                  busy_m    = 1'b1;
                  phase     = 1;
               end else if (phase == 2) begin
                  phase = cur.rd ? 3 : 4;
               end
            end
         end
         if (data_hs) begin
            if (data_q.size() == 0) begin
               chk("data_unexpected", {m_data_tlast, m_data_tdata}, '0);
            end else begin
               ed = data_q.pop_front();
               chk("data_word", {m_data_tlast, m_data_tdata}, ed);
            end
            if (phase == 1) begin
               phase = 2;
            end else if (phase == 4) begin
               phase    = 0;
               drop_cnt = 1 + int'($urandom_range(3));
            end
         end
         if (s_hs) begin
            s_drop   = 1;
            phase    = 0;
            drop_cnt = 1 + int'($urandom_range(3));
         end
         pc_valid = m_cmd_valid;   pc_hs = cmd_hs;  pc_pay = cur_cmd;
         pd_valid = m_data_tvalid; pd_hs = data_hs; pd_pay = {m_data_tlast, m_data_tdata};
      end
   end

   // Response monitor: pops the scoreboard on every rsp_valid.
   initial begin : rsp_mon
      rsp_t r;
      forever begin
         @(negedge clk);
         if (!rst && rsp_valid) begin
            if (rsp_q.size() == 0) begin
               chk("rsp_unexpected", rsp_valid, 1'b0);
            end else begin
               r = rsp_q.pop_front();
               chk("rsp_err", rsp_err, r.err);
               chk("rsp_rdata", rsp_rdata, r.rdata);
               if (r.err != 2'b10) chk("rsp_after_busy_fall", cyc - bfall_cyc, 1);
            end
         end
      end
   end

   initial begin : guard
      #1000000;
      $display("FAIL global_timeout: simulation did not finish, %0d tests run", tests);
      $fatal(1, "global timeout");
   end

   // Stimulus sequence.
   initial begin : stim
      int unsigned t0;
      int n, cnt;
      tests = 0; fails = 0;
      rst = 1'b1;
      req_valid = 1'b0; req_read = 1'b0; req_dev_addr = '0; req_reg_addr = '0; req_wdata = '0;
      force_busy = 1'b0; hold_cmd = 1'b0; hold_sdata = 1'b0; abort_ok = 1'b0; stall_pct = 0;
      repeat (3) @(negedge clk);
      #1;
      chk("reset_rsp", {rsp_valid, rsp_err, rsp_rdata}, '0);
      chk("reset_m_outputs", {m_cmd_address, m_cmd_start, m_cmd_read, m_cmd_write, m_cmd_stop,
                              m_cmd_valid, m_data_tdata, m_data_tvalid, m_data_tlast, s_data_tready}, '0);
      chk("reset_req_ready", req_ready, 1'b1);
      @(negedge clk);
      rst = 1'b0;

      // Directed zero-wait transactions.
      issue(1'b0, 7'h50, 8'h10, 8'hA5, 8'h00, 1'b0, 1'b0);
      wait_drain("drain_write");
      issue(1'b1, 7'h68, 8'h75, 8'h00, 8'h71, 1'b0, 1'b0);
      wait_drain("drain_read");
      issue(1'b0, 7'h2A, 8'h33, 8'h5C, 8'h00, 1'b1, 1'b0);
      wait_drain("drain_nack_write");
      issue(1'b1, 7'h11, 8'h44, 8'h00, 8'hEE, 1'b1, 1'b0);
      wait_drain("drain_nack_read");

      // Master busy in IDLE blocks acceptance.
      @(negedge clk);
      force_busy = 1'b1;
      model_push(1'b0, 7'h11, 8'h22, 8'h33, 8'h00, 1'b0, 1'b0);
      req_read = 1'b0; req_dev_addr = 7'h11; req_reg_addr = 8'h22; req_wdata = 8'h33;
      req_valid = 1'b1;
      cnt = 0;
      repeat (6) begin
         @(negedge clk);
         #1;
         if (req_ready || m_cmd_valid) cnt++;
      end
      chk("busy_blocks_accept", cnt, 0);
      @(negedge clk);
      force_busy = 1'b0;
      #1;
      chk("busy_release_ready", req_ready, 1'b1);
      @(negedge clk);
      req_valid = 1'b0;
      chk("busy_release_cmd", m_cmd_valid, 1'b1);
      wait_drain("drain_busy");

      // Watchdog timeout with the command never accepted.
      hold_cmd = 1'b1;
      abort_ok = 1'b1;
      issue(1'b0, 7'h3C, 8'h01, 8'h02, 8'h00, 1'b0, 1'b1);
      t0 = cyc;
      chk("timeout_cmd_entry", m_cmd_valid, 1'b1);
      n = 0;
      while (!rsp_valid && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("timeout_latency", cyc - t0, TO);
      chk("timeout_cmd_dropped", m_cmd_valid, 1'b0);
      hold_cmd = 1'b0;
      @(negedge clk);
      abort_ok = 1'b0;
      wait_drain("drain_timeout");

      // Randomised transactions under ready/valid stalls.
      stall_pct = 40;
      for (int unsigned i = 0; i < 40; i++) begin
         issue(1'($urandom), 7'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
               ($urandom_range(99) < 20), 1'b0);
      end
      wait_drain("drain_random");

      // Reset while waiting for read data.
      stall_pct  = 0;
      hold_sdata = 1'b1;
      abort_ok   = 1'b1;
      issue(1'b1, 7'h45, 8'h9A, 8'h00, 8'hC3, 1'b0, 1'b0);
      n = 0;
      while (!s_data_tready && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("rdata_reached", s_data_tready, 1'b1);
      rst = 1'b1;
      #1;
      chk("midrst_rsp", {rsp_valid, rsp_err, rsp_rdata}, '0);
      chk("midrst_m_outputs", {m_cmd_address, m_cmd_start, m_cmd_read, m_cmd_write, m_cmd_stop,
                               m_cmd_valid, m_data_tdata, m_data_tvalid, m_data_tlast, s_data_tready}, '0);
      repeat (2) @(negedge clk);
      cmd_q.delete(); data_q.delete(); txn_q.delete(); rsp_q.delete();
      rst = 1'b0;
      hold_sdata = 1'b0;
      cnt = 0;
      repeat (20) begin
         @(negedge clk);
         if (rsp_valid) cnt++;
      end
      chk("no_rsp_after_reset", cnt, 0);
      abort_ok = 1'b0;
      issue(1'b1, 7'h12, 8'h34, 8'h00, 8'h56, 1'b0, 1'b0);
      wait_drain("drain_after_reset");

      repeat (5) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
